// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: queue entry layout, register-zero constant
// and the round-robin owner of the single remaining slot.
package wb_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // "reg" is a keyword, so the destination field is called dst.
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic [XLEN-1:0]  val;
    } wb_entry_t;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_t;
endpackage

// File: rtl/wb_youngest_match.sv
// Finds the youngest queued entry whose destination equals key, searching from
// wr_ptr-1 back towards rd_ptr; key 0 never hits.
module wb_youngest_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         wr_ptr,
    input  logic [CW-1:0]         count,
    input  logic [REG_W-1:0]      key,
    output logic                  hit,
    output logic [XLEN-1:0]       val
);
    logic [PW-1:0] idx;

    always_comb begin
        hit = 1'b0;
        val = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = wr_ptr - PW'(k + 1);
            if (!hit && (CW'(k) < count) && (key != REG_ZERO) && (entries[idx].dst == key)) begin
                hit = 1'b1;
                val = entries[idx].val;
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU (A) and load (B) results into an in-order buffer that
// drains one regfile write per cycle. Bypass lookups are built only with WB_BYPASS_EN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a_valid,
    input  logic [4:0]       i_a_reg,
    input  logic [XLEN-1:0]  i_a_val,
    output logic             o_a_ready,
    input  logic             i_b_valid,
    input  logic [4:0]       i_b_reg,
    input  logic [XLEN-1:0]  i_b_val,
    output logic             o_b_ready,
    output logic [4:0]       o_wb_reg,
    output logic [XLEN-1:0]  o_wb_val,
    output logic [NREG-1:0]  o_pending,
    input  logic [4:0]       i_rd_reg0,
    input  logic [4:0]       i_rd_reg1,
    output logic             o_byp_hit0,
    output logic             o_byp_hit1,
    output logic [XLEN-1:0]  o_byp_val0,
    output logic [XLEN-1:0]  o_byp_val1
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] q;
    logic [PW-1:0] rd_ptr, wr_ptr, b_slot, slot;
    logic [CW-1:0] count, free;
    rr_t           rr;
    logic          a_hs, b_hs, push_a, push_b, pop;

    // Readiness looks only at the registered fill level, never at this cycle's pop.
    always_comb begin
        free      = CW'(DEPTH) - count;
        o_a_ready = 1'b0;
        o_b_ready = 1'b0;
        if (i_rst) begin
            if (free >= CW'(2)) begin
                o_a_ready = 1'b1;
                o_b_ready = 1'b1;
            end else if (free == CW'(1)) begin
                o_a_ready = (rr == RR_A);
                o_b_ready = (rr == RR_B);
            end
        end
    end

    assign a_hs   = i_a_valid & o_a_ready;
    assign b_hs   = i_b_valid & o_b_ready;
    assign push_a = a_hs & (i_a_reg != REG_ZERO);
    assign push_b = b_hs & (i_b_reg != REG_ZERO);
    assign pop    = (count != '0);
    assign b_slot = wr_ptr + PW'(push_a);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr     <= RR_A;
        end else begin
            if (push_a) q[wr_ptr] <= {i_a_reg, i_a_val};
            if (push_b) q[b_slot] <= {i_b_reg, i_b_val};
            wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
            if ((free == CW'(1)) && (a_hs || b_hs))
                rr <= (rr == RR_A) ? RR_B : RR_A;
        end
    end

    // Idle cycles write zero to r0, which the regfile ignores architecturally.
    always_comb begin
        o_wb_reg = '0;
        o_wb_val = '0;
        if (i_rst && pop) begin
            o_wb_reg = q[rd_ptr].dst;
            o_wb_val = q[rd_ptr].val;
        end
    end

    always_comb begin
        o_pending = '0;
        slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (i_rst && (CW'(i) < count))
                o_pending[q[slot].dst] = 1'b1;
        end
        o_pending[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    logic            hit0, hit1;
    logic [XLEN-1:0] val0, val1;

    wb_youngest_match #(.DEPTH(DEPTH)) u_match0 (
        .entries(q), .wr_ptr(wr_ptr), .count(count), .key(i_rd_reg0), .hit(hit0), .val(val0)
    );
    wb_youngest_match #(.DEPTH(DEPTH)) u_match1 (
        .entries(q), .wr_ptr(wr_ptr), .count(count), .key(i_rd_reg1), .hit(hit1), .val(val1)
    );

    assign o_byp_hit0 = i_rst & hit0;
    assign o_byp_hit1 = i_rst & hit1;
    assign o_byp_val0 = i_rst ? val0 : '0;
    assign o_byp_val1 = i_rst ? val1 : '0;
`else
    logic unused_lookup;
    assign unused_lookup = ^{i_rd_reg0, i_rd_reg1};
    assign o_byp_hit0    = 1'b0;
    assign o_byp_hit1    = 1'b0;
    assign o_byp_val0    = '0;
    assign o_byp_val1    = '0;
`endif
endmodule
